// File: rtl/sync_pkg.sv
// Shared definitions for the sync_filt synchroniser/filter family.
package sync_pkg;

    // Width of the per-bit stability counter.
    // The counter only ever holds 0..FILT-1. It is kept at least one bit
    // wide so the filtered path never declares a zero-width vector.
    function automatic int filt_cnt_w(input int filt);
        int w;
        w = $clog2(filt + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_filt_bit.sv
// Per-bit back end of sync_filt.
// It takes one synchronised bit, optionally holds it back until the value
// has been stable long enough, and produces single-cycle rise/fall pulses
// from the filtered level.
module sync_filt_bit
    import sync_pkg::*;
#(
    parameter int   FILT    = 0,
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sn,
    output logic q,
    output logic rise,
    output logic fall
);

    logic q_d;

    generate
        if (FILT == 0) begin : g_bypass
            // With no filter, the last chain stage already is the output level.
            assign q = sn;
        end else begin : g_filt
            localparam int CW = filt_cnt_w(FILT);
            typedef logic [CW-1:0] cnt_t;

            cnt_t cnt;
            logic q_r;

            // Count consecutive cycles in which the synchronised value differs
            // from q. Adopt the new value once it has persisted FILT cycles.
            // Any agreement clears the count, so short glitches are dropped.
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_r <= RST_BIT;
                    cnt <= '0;
                end else if (sn == q_r) begin
                    cnt <= '0;
                end else if (cnt == cnt_t'(FILT - 1)) begin
                    q_r <= sn;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + cnt_t'(1);
                end
            end

            assign q = q_r;
        end
    endgenerate

    // Keep last cycle's level so edges can be seen.
    // It resets together with q, so reset entry and exit never produce a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_d <= RST_BIT;
        end else begin
            q_d <= q;
        end
    end

    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/sync_filt.sv
// Parametrised multi-stage synchroniser with optional per-bit glitch filter
// and registered-source rise/fall/change event outputs.
// Only stage 0 of the chain may go metastable. The chain stages can be
// swapped for technology synchroniser cells without changing behaviour.
module sync_filt
    import sync_pkg::*;
#(
    parameter int           W       = 1,
    parameter int           N       = 2,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter int           FILT    = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall,
    output logic         chg
);

    generate
        if (N < 2) begin : g_bad_n
            $error("sync_filt: N must be at least 2");
        end
    endgenerate

    logic [N-1:0][W-1:0] s;

    // Synchroniser chain.
    // Stage 0 captures the asynchronous input, and each later stage
    // re-registers the previous one. Reset loads the reset value into every
    // stage, which discards any change that is still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= {N{RST_VAL}};
        end else begin
            s[0] <= d;
            for (int k = 1; k < N; k++) begin
                s[k] <= s[k-1];
            end
        end
    end

    generate
        for (genvar i = 0; i < W; i++) begin : g_bit
            sync_filt_bit #(
                .FILT    (FILT),
                .RST_BIT (RST_VAL[i])
            ) u_bit (
                .clk  (clk),
                .rst  (rst),
                .sn   (s[N-1][i]),
                .q    (q[i]),
                .rise (rise[i]),
                .fall (fall[i])
            );
        end
    endgenerate

    assign chg = |(rise | fall);

endmodule

// File: tb/tb_sync_filt.sv
// Self-checking bench for sync_filt.
// It drives several parameterisations from directed vector tables, and
// includes a randomised run of a wide instance against a reference model.
module tb_sync_filt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // A: W=4 N=2 FILT=0 RST_VAL=A
    logic       rst_a = 1'b1;
    logic [3:0] d_a = '0, q_a, rise_a, fall_a;
    logic       chg_a;
    // B: W=1 N=3 FILT=0
    logic rst_b = 1'b1, d_b = 1'b0, q_b, rise_b, fall_b, chg_b;
    // C: W=1 N=2 FILT=4
    logic rst_c = 1'b1, d_c = 1'b0, q_c, rise_c, fall_c, chg_c;
    // D: W=2 N=2 FILT=0
    logic       rst_d = 1'b1;
    logic [1:0] d_d = '0, q_d, rise_d, fall_d;
    logic       chg_d;
    // E: W=1 N=2 FILT=3
    logic rst_e = 1'b1, d_e = 1'b0, q_e, rise_e, fall_e, chg_e;
    // F: W=8 N=4 FILT=2 RST_VAL=3C
    logic       rst_f = 1'b1;
    logic [7:0] d_f = '0, q_f, rise_f, fall_f;
    logic       chg_f;

    sync_filt #(.W(4), .N(2), .RST_VAL(4'hA), .FILT(0)) u_a (
        .clk(clk), .rst(rst_a), .d(d_a), .q(q_a), .rise(rise_a), .fall(fall_a), .chg(chg_a));
    sync_filt #(.W(1), .N(3), .RST_VAL(1'b0), .FILT(0)) u_b (
        .clk(clk), .rst(rst_b), .d(d_b), .q(q_b), .rise(rise_b), .fall(fall_b), .chg(chg_b));
    sync_filt #(.W(1), .N(2), .RST_VAL(1'b0), .FILT(4)) u_c (
        .clk(clk), .rst(rst_c), .d(d_c), .q(q_c), .rise(rise_c), .fall(fall_c), .chg(chg_c));
    sync_filt #(.W(2), .N(2), .RST_VAL(2'b00), .FILT(0)) u_d (
        .clk(clk), .rst(rst_d), .d(d_d), .q(q_d), .rise(rise_d), .fall(fall_d), .chg(chg_d));
    sync_filt #(.W(1), .N(2), .RST_VAL(1'b0), .FILT(3)) u_e (
        .clk(clk), .rst(rst_e), .d(d_e), .q(q_e), .rise(rise_e), .fall(fall_e), .chg(chg_e));
    sync_filt #(.W(8), .N(4), .RST_VAL(8'h3C), .FILT(2)) u_f (
        .clk(clk), .rst(rst_f), .d(d_f), .q(q_f), .rise(rise_f), .fall(fall_f), .chg(chg_f));

    typedef struct {
        int         dut;
        logic       rst;
        logic [7:0] d;
        logic [7:0] q;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       chg;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // Reference state for the random run on instance F.
    localparam int F_FILT = 2;
    logic [7:0] m_s [4];
    logic [7:0] m_q, m_qd;
    int         m_run [8];

    function automatic void add(input int dut, input logic rst, input logic [7:0] d,
                                input logic [7:0] q, input logic [7:0] rise,
                                input logic [7:0] fall, input logic chg, input string name);
        vec_t v;
        v.dut = dut; v.rst = rst; v.d = d; v.q = q;
        v.rise = rise; v.fall = fall; v.chg = chg; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        case (v.dut)
            0: begin rst_a = v.rst; d_a = v.d[3:0]; end
            1: begin rst_b = v.rst; d_b = v.d[0]; end
            2: begin rst_c = v.rst; d_c = v.d[0]; end
            3: begin rst_d = v.rst; d_d = v.d[1:0]; end
            4: begin rst_e = v.rst; d_e = v.d[0]; end
            default: begin rst_f = v.rst; d_f = v.d; end
        endcase
    endtask

    function automatic logic [24:0] get_obs(input int dut);
        case (dut)
            0: return {4'h0, q_a, 4'h0, rise_a, 4'h0, fall_a, chg_a};
            1: return {7'h0, q_b, 7'h0, rise_b, 7'h0, fall_b, chg_b};
            2: return {7'h0, q_c, 7'h0, rise_c, 7'h0, fall_c, chg_c};
            3: return {6'h0, q_d, 6'h0, rise_d, 6'h0, fall_d, chg_d};
            4: return {7'h0, q_e, 7'h0, rise_e, 7'h0, fall_e, chg_e};
            default: return {q_f, rise_f, fall_f, chg_f};
        endcase
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [24:0] got, input logic [24:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s #%0d: got q=%h rise=%h fall=%h chg=%b, expected q=%h rise=%h fall=%h chg=%b",
                     name, idx, got[24:17], got[16:9], got[8:1], got[0],
                     want[24:17], want[16:9], want[8:1], want[0]);
        end
    endtask

    // Behavioural reference for F.
    // q bit follows the synchronised bit once it has disagreed with q for
    // F_FILT consecutive cycles.
    task automatic modelStep(input logic r, input logic [7:0] dv);
        logic [7:0] sn;
        sn = m_s[3];
        if (r) begin
            for (int k = 0; k < 4; k++) m_s[k] = 8'h3C;
            m_q  = 8'h3C;
            m_qd = 8'h3C;
            for (int i = 0; i < 8; i++) m_run[i] = 0;
        end else begin
            m_qd = m_q;
            for (int i = 0; i < 8; i++) begin
                if (sn[i] == m_qd[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == F_FILT) begin
                        m_q[i]   = sn[i];
                        m_run[i] = 0;
                    end
                end
            end
            for (int k = 3; k > 0; k--) m_s[k] = m_s[k-1];
            m_s[0] = dv;
        end
    endtask

    function automatic logic [24:0] model_obs();
        logic [7:0] r, f;
        r = m_q & ~m_qd;
        f = ~m_q & m_qd;
        return {m_q, r, f, |(r | f)};
    endfunction

    initial begin
        // A: reset value A, d=5 from release, plus a mid-operation reset.
        for (int i = 0; i < 3; i++) add(0, 1, 8'h0, 8'hA, 8'h0, 8'h0, 0, "A_reset");
        add(0, 0, 8'h5, 8'hA, 8'h0, 8'h0, 0, "A_release");
        add(0, 0, 8'h5, 8'h5, 8'h5, 8'hA, 1, "A_edge");
        add(0, 0, 8'h5, 8'h5, 8'h0, 8'h0, 0, "A_hold");
        add(0, 0, 8'h5, 8'h5, 8'h0, 8'h0, 0, "A_hold");
        add(0, 1, 8'h5, 8'hA, 8'h0, 8'h0, 0, "A_midreset");
        add(0, 0, 8'h5, 8'hA, 8'h0, 8'h0, 0, "A_release2");
        add(0, 0, 8'h5, 8'h5, 8'h5, 8'hA, 1, "A_edge2");
        add(0, 0, 8'h5, 8'h5, 8'h0, 8'h0, 0, "A_hold2");

        // B: three-stage latency, rise then fall.
        add(1, 1, 0, 0, 0, 0, 0, "B_reset");
        add(1, 1, 0, 0, 0, 0, 0, "B_reset");
        add(1, 0, 1, 0, 0, 0, 0, "B_lat1");
        add(1, 0, 1, 0, 0, 0, 0, "B_lat2");
        add(1, 0, 1, 1, 1, 0, 1, "B_rise");
        add(1, 0, 1, 1, 0, 0, 0, "B_hold");
        add(1, 0, 1, 1, 0, 0, 0, "B_hold");
        add(1, 0, 0, 1, 0, 0, 0, "B_flat1");
        add(1, 0, 0, 1, 0, 0, 0, "B_flat2");
        add(1, 0, 0, 0, 0, 1, 1, "B_fall");
        add(1, 0, 0, 0, 0, 0, 0, "B_low");

        // C: a 3-cycle glitch is rejected, then a stable high lands at edge 6.
        add(2, 1, 0, 0, 0, 0, 0, "C_reset");
        add(2, 1, 0, 0, 0, 0, 0, "C_reset");
        for (int i = 0; i < 3; i++) add(2, 0, 1, 0, 0, 0, 0, "C_glitch");
        for (int i = 0; i < 5; i++) add(2, 0, 0, 0, 0, 0, 0, "C_glitch_gone");
        for (int i = 0; i < 5; i++) add(2, 0, 1, 0, 0, 0, 0, "C_filtering");
        add(2, 0, 1, 1, 1, 0, 1, "C_rise");
        for (int i = 0; i < 4; i++) add(2, 0, 1, 1, 0, 0, 0, "C_hold");

        // D: both bits toggle every cycle; pulses alternate and chg stays high.
        add(3, 1, 0, 0, 0, 0, 0, "D_reset");
        add(3, 1, 0, 0, 0, 0, 0, "D_reset");
        add(3, 0, 3, 0, 0, 0, 0, "D_tog0");
        add(3, 0, 0, 3, 3, 0, 1, "D_tog_rise");
        add(3, 0, 3, 0, 0, 3, 1, "D_tog_fall");
        add(3, 0, 0, 3, 3, 0, 1, "D_tog_rise");
        add(3, 0, 3, 0, 0, 3, 1, "D_tog_fall");
        add(3, 0, 0, 3, 3, 0, 1, "D_tog_rise");
        add(3, 0, 3, 0, 0, 3, 1, "D_tog_fall");
        add(3, 0, 0, 3, 3, 0, 1, "D_tog_rise");

        // E: reset lands when the counter is one cycle from updating.
        add(4, 1, 0, 0, 0, 0, 0, "E_reset");
        add(4, 1, 0, 0, 0, 0, 0, "E_reset");
        for (int i = 0; i < 4; i++) add(4, 0, 1, 0, 0, 0, 0, "E_counting");
        add(4, 1, 1, 0, 0, 0, 0, "E_midreset");
        for (int i = 0; i < 4; i++) add(4, 0, 1, 0, 0, 0, 0, "E_recount");
        add(4, 0, 1, 1, 1, 0, 1, "E_rise");
        add(4, 0, 1, 1, 0, 0, 0, "E_hold");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput(vecs[i].name, i, get_obs(vecs[i].dut),
                        {vecs[i].q, vecs[i].rise, vecs[i].fall, vecs[i].chg});
        end

        // F: random levels held 1..6 cycles, compared against the model.
        for (int i = 0; i < 2; i++) begin
            rst_f = 1'b1;
            d_f   = 8'h00;
            modelStep(1'b1, 8'h00);
            @(posedge clk);
            #1;
            checkOutput("F_reset", i, get_obs(5), model_obs());
        end
        rst_f = 1'b0;
        for (int seg = 0; seg < 60; seg++) begin
            logic [7:0] val;
            int         hold;
            val  = 8'($urandom);
            hold = int'($urandom_range(1, 6));
            for (int c = 0; c < hold; c++) begin
                d_f = val;
                modelStep(1'b0, val);
                @(posedge clk);
                #1;
                checkOutput("F_random", seg, get_obs(5), model_obs());
                tests_run++;
                if ((rise_f & fall_f) != 8'h00) begin
                    tests_failed++;
                    $display("[TB] FAIL F_rise_and_fall #%0d: got rise&fall=%h, expected 00",
                             seg, rise_f & fall_f);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
